// File: rtl/sort_seq_ctrl.sv
// Sequential odd-even transposition sorter driving an external registered compare-swap unit.
// Define SORT_DESCENDING_EN to emit the largest element first.
module sort_seq_ctrl #(
    parameter int SIZE_DATA = 8,
    parameter int NUM_ELEM  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [SIZE_DATA-1:0] o_data,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_cmp_data_1,
    output logic [SIZE_DATA-1:0] o_cmp_data_2,
    input  logic [SIZE_DATA-1:0] i_cmp_less,
    input  logic [SIZE_DATA-1:0] i_cmp_greater,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int IW = $clog2(NUM_ELEM);
    localparam logic [IW-1:0] LAST      = IW'(NUM_ELEM - 1);
    localparam logic [IW-1:0] LAST_EVEN = IW'(NUM_ELEM - 2);
    localparam logic [IW-1:0] LAST_ODD  = IW'(NUM_ELEM - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SORT,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    state_t state, state_n;

    logic [SIZE_DATA-1:0] mem [NUM_ELEM];
    logic [IW-1:0] idx, j, j1, phase, k, wb_idx, wb_idx1;
    logic wb_en, done_q;
    logic in_xfer, out_xfer, last_pair;
    logic [SIZE_DATA-1:0] wb_lo, wb_hi;

    assign j1      = j + IW'(1);
    assign wb_idx1 = wb_idx + IW'(1);

`ifdef SORT_DESCENDING_EN
    assign wb_lo = i_cmp_greater;
    assign wb_hi = i_cmp_less;
`else
    assign wb_lo = i_cmp_less;
    assign wb_hi = i_cmp_greater;
`endif

    always_comb begin
        state_n      = state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_data       = '0;
        o_cmp_data_1 = '0;
        o_cmp_data_2 = '0;
        in_xfer      = 1'b0;
        out_xfer     = 1'b0;
        last_pair    = (j == (phase[0] ? LAST_ODD : LAST_EVEN));
        unique case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                in_xfer = i_valid;
                if (i_valid) state_n = S_LOAD;
            end
            S_LOAD: begin
                o_ready = 1'b1;
                in_xfer = i_valid;
                if (i_valid && idx == LAST) state_n = S_SORT;
            end
            S_SORT: begin
                o_cmp_data_1 = mem[j];
                o_cmp_data_2 = mem[j1];
                if (last_pair) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                state_n = (phase == LAST) ? S_UNLOAD : S_SORT;
            end
            S_UNLOAD: begin
                o_valid  = 1'b1;
                o_data   = mem[k];
                out_xfer = i_ready;
                if (i_ready && k == LAST) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        o_busy = (state != S_IDLE);
        o_done = done_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            j      <= '0;
            phase  <= '0;
            k      <= '0;
            wb_idx <= '0;
            wb_en  <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) mem[i] <= '0;
        end else begin
            state  <= state_n;
            wb_en  <= (state == S_SORT);
            wb_idx <= j;
            done_q <= (state == S_UNLOAD) && (state_n == S_IDLE);
            // compare results land one cycle after issue
            if (wb_en) begin
                mem[wb_idx]  <= wb_lo;
                mem[wb_idx1] <= wb_hi;
            end
            if (in_xfer) begin
                mem[idx] <= i_data;
                idx      <= (idx == LAST) ? '0 : idx + IW'(1);
            end
            if (out_xfer) begin
                k <= (k == LAST) ? '0 : k + IW'(1);
            end
            if (state == S_SORT && !last_pair) begin
                j <= j + IW'(2);
            end
            if (state == S_DRAIN) begin
                if (phase == LAST) begin
                    phase <= '0;
                    j     <= '0;
                end else begin
                    phase <= phase + IW'(1);
                    j     <= phase[0] ? '0 : IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Scoreboard bench for sort_seq_ctrl with a behavioural registered compare-swap unit.
// Honours SORT_DESCENDING_EN when computing expected order.
module tb_sort_seq_ctrl;

    localparam int W = 8;
    localparam int N = 8;

    typedef logic [W-1:0] vec_t [N];

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [W-1:0] i_data;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         i_ready;
    logic [W-1:0] cmp1, cmp2, cmp_less, cmp_greater;
    logic         o_busy, o_done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ld_q[$];
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        cmp_less    <= (cmp1 < cmp2) ? cmp1 : cmp2;
        cmp_greater <= (cmp1 < cmp2) ? cmp2 : cmp1;
    end

    sort_seq_ctrl #(.SIZE_DATA(W), .NUM_ELEM(N)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready),
        .o_cmp_data_1 (cmp1),
        .o_cmp_data_2 (cmp2),
        .i_cmp_less   (cmp_less),
        .i_cmp_greater(cmp_greater),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic push_expected();
        logic [W-1:0] a[$];
        logic [W-1:0] t;
        a = ld_q;
        for (int i = 1; i < a.size(); i++) begin
            for (int m = i; m > 0; m--) begin
`ifdef SORT_DESCENDING_EN
                if (a[m] > a[m-1]) begin
`else
                if (a[m] < a[m-1]) begin
`endif
                    t = a[m]; a[m] = a[m-1]; a[m-1] = t;
                end
            end
        end
        foreach (a[i]) exp_q.push_back(a[i]);
        ld_q.delete();
    endtask

    task automatic load_words(input vec_t w, input bit gap);
        for (int i = 0; i < N; i++) begin
            if (gap) begin
                @(negedge clk);
                i_valid = 1'b0;
            end
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = w[i];
            ld_q.push_back(w[i]);
        end
        @(negedge clk);
        i_valid = 1'b0;
        push_expected();
    endtask

    task automatic wait_unload(output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b valid=%b done=%b required 0/0/0", o_busy, o_valid, o_done);
        end
        checks++;
        if (o_data !== '0 || cmp1 !== '0 || cmp2 !== '0) begin
            failures++;
            $display("FAIL reset_data: o_data=%0d cmp1=%0d cmp2=%0d required 0", o_data, cmp1, cmp2);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: o_ready=%b required 1", o_ready);
        end
    endtask

    task automatic test_sort_basic();
        vec_t v;
        int cyc, n;
        v = '{8'd7, 8'd3, 8'd5, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        load_words(v, 1'b0);
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL sort_state: ready=%b busy=%b required 0/1", o_ready, o_busy);
        end
        wait_unload(cyc);
        checks++;
        if (cyc !== 36) begin
            failures++;
            $display("FAIL sort_cycles: got %0d required 36", cyc);
        end
        n = 0;
        while (n < N && exp_q.size() > 0) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0]) begin
                failures++;
                $display("FAIL basic_out[%0d]: valid=%b data=%0d required 1/%0d", n, o_valid, o_data, exp_q[0]);
            end
            if (n == 0) begin
                checks++;
                if (cmp1 !== '0) begin
                    failures++;
                    $display("FAIL unload_cmp: cmp1=%0d required 0", cmp1);
                end
            end
            void'(exp_q.pop_front());
            n++;
            @(negedge clk);
        end
        checks++;
        if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: done=%b valid=%b busy=%b required 1/0/0", o_done, o_valid, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b required 0", o_done);
        end
    endtask

    task automatic test_toggle_valid();
        vec_t v;
        int cyc, n, guard;
        v = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd5};
        load_words(v, 1'b1);
        wait_unload(cyc);
        checks++;
        if (cyc !== 36) begin
            failures++;
            $display("FAIL toggle_cycles: got %0d required 36", cyc);
        end
        n = 0; guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            guard++;
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0]) begin
                failures++;
                $display("FAIL toggle_out[%0d]: valid=%b data=%0d required 1/%0d", n, o_valid, o_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n++;
            @(negedge clk);
        end
        checks++;
        if (o_done !== 1'b1 || n !== N) begin
            failures++;
            $display("FAIL toggle_done: done=%b count=%0d required 1/%0d", o_done, n, N);
        end
    endtask

    task automatic test_hold_ready();
        vec_t v;
        int cyc, n, hold, guard;
        v = '{8'd40, 8'd10, 8'd70, 8'd20, 8'd80, 8'd30, 8'd60, 8'd50};
        load_words(v, 1'b0);
        wait_unload(cyc);
        n = 0; hold = 0; guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            guard++;
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0]) begin
                failures++;
                $display("FAIL hold_out[%0d]: valid=%b data=%0d required 1/%0d", n, o_valid, o_data, exp_q[0]);
            end
            if (n == 3 && hold < 4) begin
                i_ready = 1'b0;
                hold++;
            end else begin
                i_ready = 1'b1;
                void'(exp_q.pop_front());
                n++;
            end
            @(negedge clk);
        end
        i_ready = 1'b1;
        checks++;
        if (o_done !== 1'b1 || hold !== 4) begin
            failures++;
            $display("FAIL hold_done: done=%b holds=%0d required 1/4", o_done, hold);
        end
    endtask

    task automatic test_ignore_during_sort();
        vec_t v;
        int cyc, n;
        v = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4};
        load_words(v, 1'b0);
        cyc = 0;
        while (!o_valid && cyc < 200) begin
            cyc++;
            if (cyc == 5) begin
                i_valid = 1'b1;
                i_data  = 8'd9;
                checks++;
                if (o_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_ready: o_ready=%b required 0", o_ready);
                end
            end
            if (cyc == 9) i_valid = 1'b0;
            @(negedge clk);
        end
        i_valid = 1'b0;
        checks++;
        if (cyc !== 36) begin
            failures++;
            $display("FAIL ignore_cycles: got %0d required 36", cyc);
        end
        n = 0;
        while (exp_q.size() > 0 && n < N) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0]) begin
                failures++;
                $display("FAIL ignore_out[%0d]: valid=%b data=%0d required 1/%0d", n, o_valid, o_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_sort();
        vec_t v;
        int cyc, n, bad;
        v = '{8'd7, 8'd3, 8'd5, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        load_words(v, 1'b0);
        cyc = 1;
        while (cyc < 10) begin
            cyc++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int pass = 0; pass < 2; pass++) begin
            bad = 0;
            for (int i = 0; i < N; i++) if (dut.mem[i] !== '0) bad++;
            checks++;
            if (bad !== 0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
                failures++;
                $display("FAIL midrst_clear[%0d]: nonzero=%0d busy=%b ready=%b required 0/0/1", pass, bad, o_busy, o_ready);
            end
            @(negedge clk);
        end
        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_words(v, 1'b0);
        wait_unload(cyc);
        n = 0;
        while (exp_q.size() > 0 && n < N) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_q[0]) begin
                failures++;
                $display("FAIL midrst_out[%0d]: valid=%b data=%0d required 1/%0d", n, o_valid, o_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n++;
            @(negedge clk);
        end
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL midrst_done: done=%b required 1", o_done);
        end
    endtask

    initial begin
        test_reset();
        test_sort_basic();
        test_toggle_valid();
        test_hold_ready();
        test_ignore_during_sort();
        test_reset_mid_sort();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_seq_ctrl.md
SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, meaning element width in bits.
REQ-002 SHALL have parameter NUM_ELEM, default 8, meaning element count; even, >=4.
REQ-003 SHALL have ports: i_clk  in  1  clock; one clock, all state updates on rising edge.
REQ-004 SHALL have ports: i_rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports: i_valid  in  1  input word valid; i_data  in  SIZE_DATA  input word; o_ready  out  1  load ready.
REQ-006 SHALL have ports: o_valid  out  1  output word valid; o_data  out  SIZE_DATA  output word; i_ready  in  1  output accept.
REQ-007 SHALL have ports: o_cmp_data_1, o_cmp_data_2  out  SIZE_DATA  operands to external registered compare-swap unit; i_cmp_less, i_cmp_greater  in  SIZE_DATA  its results, valid one cycle after issue.
REQ-008 SHALL have ports: o_busy  out  1  high in LOAD/SORT/DRAIN/UNLOAD; o_done  out  1  one-cycle pulse after last word unloaded.

Function
REQ-009 SHALL hold NUM_ELEM-entry register array mem[0..NUM_ELEM-1] and run odd-even transposition sort using only the external compare unit.
REQ-010 SHALL implement states IDLE, LOAD, SORT, DRAIN, UNLOAD.
REQ-011 IDLE: o_ready=1; transfer (i_valid&&o_ready) writes mem[0], goes to LOAD with load index 1.
REQ-012 LOAD: o_ready=1; each transfer writes mem[idx], idx++; transfer writing mem[NUM_ELEM-1] goes to SORT, phase 0, pair j=0.
REQ-013 SHALL drive o_ready=0 outside IDLE/LOAD; i_valid there SHALL be ignored, no mem change.
REQ-014 Phase p even: pairs (0,1),(2,3),...,(N-2,N-1) (N/2 pairs); p odd: (1,2),...,(N-3,N-2) (N/2-1 pairs).
REQ-015 SORT: one pair per cycle, o_cmp_data_1=mem[j], o_cmp_data_2=mem[j+1]; operands SHALL be 0 in all other states.
REQ-016 Cycle after each issue SHALL write mem[j]=i_cmp_less, mem[j+1]=i_cmp_greater (delayed index and write-enable register).
REQ-017 After last pair of a phase SHALL enter DRAIN for exactly one cycle (final writeback), then SORT with p+1, or UNLOAD if p was NUM_ELEM-1.
REQ-018 Sort length SHALL be NUM_ELEM phases; NUM_ELEM=8 gives 36 cycles from first SORT cycle to first UNLOAD cycle.
REQ-019 UNLOAD: o_valid=1, o_data=mem[k], k from 0; k advances only on o_valid&&i_ready; o_data stable while i_ready=0.
REQ-020 Transfer of k=NUM_ELEM-1 SHALL go to IDLE and assert o_done for that following cycle only.
REQ-021 Equal elements SHALL be written back as returned; order among equals not guaranteed.

Reset
REQ-022 i_rst=1 SHALL force IDLE, all indices/phase 0, write-enable 0, o_valid=0, o_data=0, o_busy=0, o_done=0, operands 0; mem cleared to 0.
REQ-023 Reset mid-LOAD/SORT/UNLOAD SHALL abandon the operation; in-flight compare result SHALL NOT be written.
REQ-024 First cycle after reset release SHALL present o_ready=1.

Configuration
REQ-025 Macro SORT_DESCENDING_EN defined: writeback SHALL be mem[j]=i_cmp_greater, mem[j+1]=i_cmp_less (output largest first); undefined: ascending per REQ-016.
REQ-026 Macro SHALL NOT change timing, ports or state sequence.

Verification
REQ-027 Load 7,3,5,1,8,2,6,4 (N=8, i_ready=1) -> outputs 1,2,3,4,5,6,7,8, o_done one cycle after 8 transferred, 36 SORT+DRAIN cycles.
REQ-028 Same input with SORT_DESCENDING_EN -> 8,7,6,5,4,3,2,1.
REQ-029 Load 5,5,0,255,5,0,255,5 with i_valid toggling every other cycle -> 0,0,5,5,5,5,255,255; no word lost or duplicated.
REQ-030 Hold i_ready=0 for 4 cycles at k=3 -> o_data stays mem[3], then resumes 4..7 in order.
REQ-031 Assert i_rst for one cycle at SORT cycle 10 -> IDLE, o_busy=0, mem all 0; new load 8..1 sorts correctly to 1..8.
REQ-032 Drive i_valid with 9 during SORT -> o_ready=0, word ignored, result unaffected.
